// File: rtl/control_loop_sequencer_if.sv
// ADC / math-unit / DAC handshake bundle for control_loop_sequencer.
// master = sequencer side, slave = peripheral side.
interface control_loop_sequencer_if #(
  parameter int CONSTS_WHOLE    = 21,
  parameter int CONSTS_FRAC     = 43,
  parameter int ADC_WID         = 18,
  parameter int DAC_WID         = 20,
  parameter int CYCLE_COUNT_WID = 18
);
  localparam int CW = CONSTS_WHOLE + CONSTS_FRAC;
  localparam int EW = DAC_WID + 1;

  logic                       adc_arm;
  logic                       adc_finished;
  logic signed [ADC_WID-1:0]  adc_data;

  logic                       math_arm;
  logic                       math_finished;
  logic [ADC_WID-1:0]         math_setpt;
  logic [ADC_WID-1:0]         math_measured;
  logic [CW-1:0]              math_cl_P;
  logic [CW-1:0]              math_cl_I;
  logic [CYCLE_COUNT_WID-1:0] math_cycles;
  logic [EW-1:0]              math_e_prev;
  logic [CW-1:0]              math_adjval_prev;
  logic [EW-1:0]              math_e_cur;
  logic [CW-1:0]              math_adj_val;

  logic                       dac_arm;
  logic                       dac_finished;
  logic signed [DAC_WID-1:0]  dac_data;

  modport master (
    output adc_arm, math_arm, math_setpt, math_measured, math_cl_P, math_cl_I,
           math_cycles, math_e_prev, math_adjval_prev, dac_arm, dac_data,
    input  adc_finished, adc_data, math_finished, math_e_cur, math_adj_val, dac_finished
  );

  modport slave (
    input  adc_arm, math_arm, math_setpt, math_measured, math_cl_P, math_cl_I,
           math_cycles, math_e_prev, math_adjval_prev, dac_arm, dac_data,
    output adc_finished, adc_data, math_finished, math_e_cur, math_adj_val, dac_finished
  );
endinterface

// File: rtl/control_loop_sequencer.sv
// Sequences ADC -> math -> DAC arm/finished handshakes each loop iteration while run is high.
// Define CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN to add the iter_count output.
module control_loop_sequencer #(
  parameter int CONSTS_WHOLE    = 21,
  parameter int CONSTS_FRAC     = 43,
  parameter int ADC_WID         = 18,
  parameter int DAC_WID         = 20,
  parameter int CYCLE_COUNT_WID = 18
) (
  input  logic                                      clk,
  input  logic                                      rst_L,
  input  logic                                      run,
  input  logic signed [ADC_WID-1:0]                 setpt,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0] cl_P,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0] cl_I,
  control_loop_sequencer_if.master                  bus,
  output logic                                      busy,
  output logic signed [ADC_WID-1:0]                 last_measured,
  output logic signed [DAC_WID-1:0]                 last_dac
`ifdef CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN
  ,
  output logic [31:0]                               iter_count
`endif
);
  localparam int CW = CONSTS_WHOLE + CONSTS_FRAC;
  localparam logic [CYCLE_COUNT_WID-1:0] CYC_ONE = {{(CYCLE_COUNT_WID-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_COUNT_WID-1:0] CYC_MAX = {1'b0, {(CYCLE_COUNT_WID-1){1'b1}}};
  localparam logic signed [CONSTS_WHOLE-1:0] DAC_MAX = CONSTS_WHOLE'(2**(DAC_WID-1) - 1);
  localparam logic signed [CONSTS_WHOLE-1:0] DAC_MIN = CONSTS_WHOLE'(-(2**(DAC_WID-1)));

  typedef enum logic [2:0] {
    IDLE, ADC_WAIT, ADC_REL, MATH_WAIT, MATH_REL, DAC_WAIT, DAC_REL
  } state_t;

  state_t                     state;
  logic [CYCLE_COUNT_WID-1:0] cyc_cnt;
  logic                       math_arm_edge;
  logic signed [CONSTS_WHOLE-1:0] adj_int;
  logic signed [DAC_WID-1:0]  dac_sat;

  assign busy          = (state != IDLE);
  assign math_arm_edge = (state == ADC_REL) && !bus.adc_finished;

  // Integer field of the Q format; dropping the fraction bits floors toward -inf.
  always_comb begin
    adj_int = bus.math_adj_val[CW-1:CONSTS_FRAC];
    dac_sat = adj_int[DAC_WID-1:0];
    if (adj_int > DAC_MAX) begin
      dac_sat = DAC_MAX[DAC_WID-1:0];
    end else if (adj_int < DAC_MIN) begin
      dac_sat = DAC_MIN[DAC_WID-1:0];
    end
  end

  // Zero means "never armed since reset"; the first iteration then reports 1.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cyc_cnt <= '0;
    end else if (math_arm_edge) begin
      cyc_cnt <= CYC_ONE;
    end else if (cyc_cnt != '0 && cyc_cnt != CYC_MAX) begin
      cyc_cnt <= cyc_cnt + CYC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state                <= IDLE;
      bus.adc_arm          <= 1'b0;
      bus.math_arm         <= 1'b0;
      bus.dac_arm          <= 1'b0;
      bus.math_setpt       <= '0;
      bus.math_measured    <= '0;
      bus.math_cl_P        <= '0;
      bus.math_cl_I        <= '0;
      bus.math_cycles      <= '0;
      bus.math_e_prev      <= '0;
      bus.math_adjval_prev <= '0;
      bus.dac_data         <= '0;
      last_measured        <= '0;
      last_dac             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state       <= ADC_WAIT;
            bus.adc_arm <= 1'b1;
          end
        end
        ADC_WAIT: begin
          if (bus.adc_finished) begin
            state             <= ADC_REL;
            bus.adc_arm       <= 1'b0;
            last_measured     <= bus.adc_data;
            bus.math_measured <= bus.adc_data;
          end
        end
        ADC_REL: begin
          if (!bus.adc_finished) begin
            state            <= MATH_WAIT;
            bus.math_arm     <= 1'b1;
            bus.math_setpt   <= setpt;
            bus.math_cl_P    <= cl_P;
            bus.math_cl_I    <= cl_I;
            bus.math_cycles  <= (cyc_cnt == '0) ? CYC_ONE : cyc_cnt;
          end
        end
        MATH_WAIT: begin
          if (bus.math_finished) begin
            state                <= MATH_REL;
            bus.math_arm         <= 1'b0;
            bus.math_e_prev      <= bus.math_e_cur;
            bus.math_adjval_prev <= bus.math_adj_val;
            bus.dac_data         <= dac_sat;
          end
        end
        MATH_REL: begin
          if (!bus.math_finished) begin
            state       <= DAC_WAIT;
            bus.dac_arm <= 1'b1;
          end
        end
        DAC_WAIT: begin
          if (bus.dac_finished) begin
            state       <= DAC_REL;
            bus.dac_arm <= 1'b0;
            last_dac    <= bus.dac_data;
          end
        end
        DAC_REL: begin
          if (!bus.dac_finished) begin
            if (run) begin
              state       <= ADC_WAIT;
              bus.adc_arm <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      iter_count <= '0;
    end else if (state == DAC_WAIT && bus.dac_finished) begin
      iter_count <= iter_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_control_loop_sequencer.sv
// Randomized bench: acts as ADC, math unit and DAC, and checks the sequencer against
// a transaction-level model (per-iteration expectations, saturation and gap arithmetic).
module tb_control_loop_sequencer;
  localparam int CWH = 21;
  localparam int CFR = 43;
  localparam int AW  = 18;
  localparam int DW  = 20;
  localparam int CCW = 12;
  localparam int CW  = CWH + CFR;
  localparam int EW  = DW + 1;
  localparam int SAT = 2**(CCW-1) - 1;
  localparam int TMO = 200;
  localparam int LONG_IDLE = 2600;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic run = 1'b0;
  logic signed [AW-1:0] setpt = '0;
  logic signed [CW-1:0] cl_P = '0;
  logic signed [CW-1:0] cl_I = '0;
  logic busy;
  logic signed [AW-1:0] last_measured;
  logic signed [DW-1:0] last_dac;
`ifdef CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN
  logic [31:0] iter_count;
`endif

  control_loop_sequencer_if #(.CONSTS_WHOLE(CWH), .CONSTS_FRAC(CFR), .ADC_WID(AW),
                              .DAC_WID(DW), .CYCLE_COUNT_WID(CCW)) bus ();

  control_loop_sequencer #(.CONSTS_WHOLE(CWH), .CONSTS_FRAC(CFR), .ADC_WID(AW),
                           .DAC_WID(DW), .CYCLE_COUNT_WID(CCW)) dut (
    .clk           (clk),
    .rst_L         (rst_L),
    .run           (run),
    .setpt         (setpt),
    .cl_P          (cl_P),
    .cl_I          (cl_I),
    .bus           (bus),
    .busy          (busy),
    .last_measured (last_measured),
    .last_dac      (last_dac)
`ifdef CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN
    ,
    .iter_count    (iter_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the next iteration should present.
  logic [EW-1:0] m_e_prev;
  logic [CW-1:0] m_adj_prev;
  logic [DW-1:0] m_last_dac;
  logic [31:0]   m_iters;
  bit            m_first;
  int            m_last_arm;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_e_prev   = '0;
    m_adj_prev = '0;
    m_last_dac = '0;
    m_iters    = '0;
    m_first    = 1'b1;
    m_last_arm = 0;
  endtask

  function automatic logic [DW-1:0] sat_model(input logic [CW-1:0] a);
    longint ip;
    ip = $signed(a) >>> CFR;
    if (ip > longint'(2**(DW-1) - 1)) return {1'b0, {(DW-1){1'b1}}};
    if (ip < -longint'(2**(DW-1)))   return {1'b1, {(DW-1){1'b0}}};
    return ip[DW-1:0];
  endfunction

  function automatic logic [CW-1:0] mk_adj(input longint ip, input logic [CFR-1:0] fr);
    return (CW'(ip) << CFR) | CW'(fr);
  endfunction

  function automatic logic [CW-1:0] rand_adj();
    logic [CW-1:0] r;
    longint ip;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0: return r;
      1: begin
        ip = longint'($urandom_range(0, 1200000)) - 600000;
        return mk_adj(ip, r[CFR-1:0]);
      end
      default: begin
        ip = longint'($urandom_range(0, 2000)) - 1000;
        return mk_adj(ip, r[CFR-1:0]);
      end
    endcase
  endfunction

  function automatic logic arm_of(input int s);
    case (s)
      0:       return bus.adc_arm;
      1:       return bus.math_arm;
      default: return bus.dac_arm;
    endcase
  endfunction

  task automatic wait_arm(input int s, input logic lvl, input string tag);
    int n;
    n = 0;
    while (arm_of(s) !== lvl && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (arm_of(s) !== lvl) chk({tag, "_timeout"}, 64'(arm_of(s)), 64'(lvl));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_adc_arm"},   64'(bus.adc_arm), 64'd0);
    chk({tag, "_math_arm"},  64'(bus.math_arm), 64'd0);
    chk({tag, "_dac_arm"},   64'(bus.dac_arm), 64'd0);
    chk({tag, "_dac_data"},  64'({bus.dac_data}), 64'd0);
    chk({tag, "_last_dac"},  64'({last_dac}), 64'd0);
    chk({tag, "_last_meas"}, 64'({last_measured}), 64'd0);
    chk({tag, "_e_prev"},    64'(bus.math_e_prev), 64'd0);
    chk({tag, "_adj_prev"},  64'(bus.math_adjval_prev), 64'd0);
    chk({tag, "_cycles"},    64'(bus.math_cycles), 64'd0);
    chk({tag, "_setpt"},     64'(bus.math_setpt), 64'd0);
  endtask

  task automatic do_iter(input bit fix, input logic [AW-1:0] adc_fix, input logic [CW-1:0] adj_fix,
                         input bit drop_run, input bit prefire, input bit rst_in_math);
    logic [AW-1:0]  adc_v;
    logic [AW-1:0]  sp;
    logic [CW-1:0]  adj_v;
    logic [CW-1:0]  cp;
    logic [CW-1:0]  ci;
    logic [EW-1:0]  e_v;
    logic [DW-1:0]  exp_dac;
    logic [CCW-1:0] exp_cyc;
    int gap;
    sp = AW'($urandom);
    cp = {$urandom, $urandom};
    ci = {$urandom, $urandom};
    setpt = sp;
    cl_P  = cp;
    cl_I  = ci;

    // ADC handshake
    wait_arm(0, 1'b1, "adc_arm_rise");
    if (drop_run) run = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    adc_v = fix ? adc_fix : AW'($urandom);
    bus.adc_data = adc_v;
    bus.adc_finished = 1'b1;
    wait_arm(0, 1'b0, "adc_arm_fall");
    chk("last_measured", 64'({last_measured}), 64'(adc_v));
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("math_arm_while_adc_fin", 64'(bus.math_arm), 64'd0);
    bus.adc_finished = 1'b0;
    bus.adc_data = AW'($urandom);

    // Math handshake
    wait_arm(1, 1'b1, "math_arm_rise");
    gap = cyc - m_last_arm;
    exp_cyc = m_first ? CCW'(1) : CCW'((gap > SAT) ? SAT : gap);
    m_first = 1'b0;
    m_last_arm = cyc;
    chk("math_cycles",   64'(bus.math_cycles), 64'(exp_cyc));
    chk("math_setpt",    64'(bus.math_setpt), 64'(sp));
    chk("math_cl_P",     64'(bus.math_cl_P), 64'(cp));
    chk("math_cl_I",     64'(bus.math_cl_I), 64'(ci));
    chk("math_measured", 64'(bus.math_measured), 64'(adc_v));
    chk("math_e_prev",   64'(bus.math_e_prev), 64'(m_e_prev));
    chk("math_adj_prev", 64'(bus.math_adjval_prev), 64'(m_adj_prev));
    setpt = AW'($urandom);
    cl_P  = {$urandom, $urandom};
    cl_I  = {$urandom, $urandom};

    if (rst_in_math) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #2 rst_L = 1'b0;
      #1 chk_reset("rst_math");
      run = 1'b0;
      @(negedge clk);
      rst_L = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_rel_busy", 64'(busy), 64'd0);
      chk("rst_rel_adc_arm", 64'(bus.adc_arm), 64'd0);
      return;
    end

    repeat ($urandom_range(0, 5)) @(negedge clk);
    e_v   = EW'($urandom);
    adj_v = fix ? adj_fix : rand_adj();
    bus.math_e_cur = e_v;
    bus.math_adj_val = adj_v;
    bus.math_finished = 1'b1;
    wait_arm(1, 1'b0, "math_arm_fall");
    chk("e_prev_capture",   64'(bus.math_e_prev), 64'(e_v));
    chk("adj_prev_capture", 64'(bus.math_adjval_prev), 64'(adj_v));
    chk("math_setpt_hold",  64'(bus.math_setpt), 64'(sp));
    m_e_prev   = e_v;
    m_adj_prev = adj_v;
    exp_dac    = sat_model(adj_v);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("dac_arm_while_math_fin", 64'(bus.dac_arm), 64'd0);
    bus.math_finished = 1'b0;
    bus.math_e_cur = EW'($urandom);
    bus.math_adj_val = {$urandom, $urandom};

    // DAC handshake; prefire holds finished high before arm rises
    if (prefire) begin
      bus.dac_finished = 1'b1;
      @(negedge clk);
      chk("prefire_arm_high", 64'(bus.dac_arm), 64'd1);
      chk("dac_data", 64'({bus.dac_data}), 64'(exp_dac));
      @(negedge clk);
      chk("prefire_arm_low", 64'(bus.dac_arm), 64'd0);
    end else begin
      wait_arm(2, 1'b1, "dac_arm_rise");
      chk("dac_data", 64'({bus.dac_data}), 64'(exp_dac));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.dac_finished = 1'b1;
      wait_arm(2, 1'b0, "dac_arm_fall");
    end
    m_last_dac = exp_dac;
    m_iters = m_iters + 32'd1;
    chk("last_dac", 64'({last_dac}), 64'(m_last_dac));
`ifdef CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN
    chk("iter_count", 64'(iter_count), 64'(m_iters));
`endif
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("adc_arm_while_dac_fin", 64'(bus.adc_arm), 64'd0);
    chk("dac_data_hold", 64'({bus.dac_data}), 64'(exp_dac));
    bus.dac_finished = 1'b0;
    if (drop_run) begin
      repeat (3) @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_adc_arm", 64'(bus.adc_arm), 64'd0);
    end
  endtask

  initial begin
    bus.adc_finished  = 1'b0;
    bus.adc_data      = '0;
    bus.math_finished = 1'b0;
    bus.math_e_cur    = '0;
    bus.math_adj_val  = '0;
    bus.dac_finished  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_L = 1'b1;
    @(negedge clk);
    chk("por_idle_busy", 64'(busy), 64'd0);

    // Directed values: nominal, both saturation rails, and a negative fraction
    run = 1'b1;
    do_iter(1'b1, 18'h00100, mk_adj(1234, '0), 1'b0, 1'b0, 1'b0);
    do_iter(1'b1, AW'($urandom), mk_adj(600000, '0), 1'b0, 1'b0, 1'b0);
    do_iter(1'b1, AW'($urandom), mk_adj(-600000, '0), 1'b0, 1'b1, 1'b0);
    do_iter(1'b1, AW'($urandom), mk_adj(-1, 43'h400_0000_0000), 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      do_iter(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // run dropped mid-iteration, then a long idle to saturate the cycle counter
    do_iter(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (LONG_IDLE) @(negedge clk);
    chk("long_idle_busy", 64'(busy), 64'd0);
    run = 1'b1;
    do_iter(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    do_iter(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset during MATH_WAIT, then restart from clean history
    do_iter(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_iter(1'b0, '0, '0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
      run = 1'b1;
    end
    do_iter(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_loop_sequencer.md
CONTROL_LOOP_SEQUENCER -- requirements
Module: control_loop_sequencer

Interface
REQ-001 SHALL have parameters: CONSTS_WHOLE, default 21, integer bits incl. sign; CONSTS_FRAC, default 43, fraction bits; ADC_WID, default 18; DAC_WID, default 20; CYCLE_COUNT_WID, default 18. CW = CONSTS_WHOLE+CONSTS_FRAC; EW = DAC_WID+1.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk in 1, system clock; rst_L in 1, async active-low reset.
REQ-003 SHALL have loop inputs: run in 1, loop enable; setpt in ADC_WID signed, setpoint; cl_P in CW signed, P constant; cl_I in CW signed, I constant.
REQ-004 SHALL have ADC side: adc_arm out 1, start conversion; adc_finished in 1, conversion done; adc_data in ADC_WID signed, sample.
REQ-005 SHALL have math-unit side: math_arm out 1; math_finished in 1; math_setpt out ADC_WID; math_measured out ADC_WID; math_cl_P out CW; math_cl_I out CW; math_cycles out CYCLE_COUNT_WID; math_e_prev out EW; math_adjval_prev out CW; math_e_cur in EW; math_adj_val in CW.
REQ-006 SHALL have DAC side: dac_arm out 1; dac_finished in 1; dac_data out DAC_WID signed, DAC code.
REQ-007 SHALL have status: busy out 1, high whenever state is not IDLE; last_measured out ADC_WID, last ADC sample; last_dac out DAC_WID, last code written.

Function
REQ-008 SHALL sequence states IDLE -> ADC_WAIT -> ADC_REL -> MATH_WAIT -> MATH_REL -> DAC_WAIT -> DAC_REL -> (ADC_WAIT if run, else IDLE); IDLE -> ADC_WAIT when run=1.
REQ-009 SHALL, in all three handshakes, hold arm high until finished=1, then drop arm on the next edge and remain in the *_REL state until finished=0.
REQ-010 SHALL, on entry to ADC_WAIT, assert adc_arm; on adc_finished=1, register adc_data into last_measured and math_measured.
REQ-011 SHALL, on entry to MATH_WAIT, register setpt, cl_P, cl_I into math_setpt/math_cl_P/math_cl_I, present math_cycles, and assert math_arm; these outputs stay stable until math_finished=0 in MATH_REL.
REQ-012 SHALL keep a free-running cycle counter: cleared to 1 on the edge math_arm rises, +1 per clk, saturating at 2^(CYCLE_COUNT_WID-1)-1 (131071); math_cycles = counter value at the arming edge; first iteration after reset presents 1.
REQ-013 SHALL, on math_finished=1, register math_e_cur into math_e_prev and math_adj_val into math_adjval_prev (values used on the next iteration).
REQ-014 SHALL form dac_data from math_adj_val integer field [CW-1:CONSTS_FRAC], saturated to signed DAC_WID: >2^(DAC_WID-1)-1 -> 0x7FFFF; <-2^(DAC_WID-1) -> 0x80000; fraction truncated toward -inf.
REQ-015 SHALL assert dac_arm on entry to DAC_WAIT with dac_data stable until DAC_REL exits; last_dac updated on dac_finished=1.
REQ-016 SHALL complete the current iteration when run falls mid-iteration; run is sampled only in DAC_REL exit and IDLE.
REQ-017 SHALL ignore finished inputs in states not waiting for them; a finished already high on arm entry is accepted one cycle after arm rises, never before.
REQ-018 SHALL retain math_e_prev/math_adjval_prev across run toggles; cleared only by reset.

Reset
REQ-019 SHALL, on rst_L=0, immediately force state IDLE, all arm outputs 0, busy 0, counter 0, and every data/status output 0.
REQ-020 SHALL abandon any in-flight handshake on reset; after release, the first iteration begins from IDLE with e_prev=0, adjval_prev=0.

Configuration
REQ-021 SHALL support macro CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN: when defined, adds output iter_count out 32, incremented (wrapping at 2^32) on each dac_finished acceptance, reset 0; when undefined, the port and counter are absent and behaviour is otherwise identical.

Verification
REQ-022 Reset mid MATH_WAIT -> math_arm 0 same cycle as rst_L low, all outputs 0, IDLE after release.
REQ-023 run=1, ADC returns 0x00100, math returns adj_val integer 1234 -> dac_data=1234, last_measured=0x00100, math_e_prev=math_e_cur.
REQ-024 math_adj_val integer 600000 -> dac_data 0x7FFFF; integer -600000 -> 0x80000; -0.5 -> 0xFFFFF (-1).
REQ-025 200000 clk between math arms -> math_cycles=131071; back-to-back iterations with 50 clk gap -> math_cycles=50.
REQ-026 run dropped during ADC_WAIT -> iteration finishes one DAC write, then IDLE, busy 0; finished held high -> no re-arm until it falls.
REQ-027 With CONTROL_LOOP_SEQUENCER_ITER_COUNT_EN, 5 iterations -> iter_count=5; without it, build has no iter_count port.
